outer_product_stream: RTL and testbench

//  Parametrised clk2-side outer-product engine for the handshake->FIFO matrix path.
//  - Collects vector A (N elements), then vector B (N elements), over a valid/ready input.
//  - Streams all N*N products A[i]*B[j] in row-major order over a valid/ready output, one per cycle.
//  - Output backpressure comes from the downstream FIFO: out_ready = !fifo_full.
//  - Generalises the fixed 16x16, 4-bit, unsigned, compute-all-then-drain engine:

---
 rtl/outer_product_stream.sv | 141 ++++++++++++++
 tb/tb_outer_product_stream.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/outer_product_stream.sv
// Outer-product engine: loads vectors A then B, streams A[row]*B[col] in row-major order.
// Define OPS_SIGNED_EN for two's complement operands; the default build multiplies unsigned.
module outer_product_stream #(
    parameter int unsigned N  = 16,
    parameter int unsigned DW = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    input  logic [DW-1:0]   i_in_data,
    output logic            o_in_ready,
    input  logic            i_abort,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [2*DW-1:0] o_out_data,
    output logic            o_out_last,
    output logic            o_busy
);

    localparam int unsigned PW = 2 * DW;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned LW = $clog2(2 * N);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStream
    } state_e;

    state_e          r_state, w_state_d;
    logic [LW-1:0]   r_ld_cnt, w_ld_cnt_d;
    logic [IW-1:0]   r_row, w_row_d;
    logic [IW-1:0]   r_col, w_col_d;
    logic [DW-1:0]   r_a [N];
    logic [DW-1:0]   r_b [N];

    logic            w_accept;
    logic            w_out_hs;
    logic            w_wr_a;
    logic            w_wr_b;
    logic [IW-1:0]   w_wr_idx;
    logic [PW-1:0]   w_a_ext;
    logic [PW-1:0]   w_b_ext;
    logic [PW-1:0]   w_prod;

    assign w_accept = i_in_valid && (r_state != StStream) && !i_abort;
    assign w_out_hs = (r_state == StStream) && i_out_ready;

    always_comb begin
        w_state_d  = r_state;
        w_ld_cnt_d = r_ld_cnt;
        w_row_d    = r_row;
        w_col_d    = r_col;
        w_wr_a     = 1'b0;
        w_wr_b     = 1'b0;
        w_wr_idx   = (r_ld_cnt < LW'(N)) ? IW'(r_ld_cnt) : IW'(r_ld_cnt - LW'(N));
        if (i_abort) begin
            w_state_d  = StIdle;
            w_ld_cnt_d = '0;
            w_row_d    = '0;
            w_col_d    = '0;
        end else begin
            unique case (r_state)
                StIdle, StLoad: begin
                    if (w_accept) begin
                        w_wr_a = (r_ld_cnt < LW'(N));
                        w_wr_b = !(r_ld_cnt < LW'(N));
                        if (r_ld_cnt == LW'(2 * N - 1)) begin
                            w_state_d  = StStream;
                            w_ld_cnt_d = '0;
                            w_row_d    = '0;
                            w_col_d    = '0;
                        end else begin
                            w_state_d  = StLoad;
                            w_ld_cnt_d = r_ld_cnt + 1'b1;
                        end
                    end
                end
                StStream: begin
                    if (w_out_hs) begin
                        if (r_col == IW'(N - 1)) begin
                            w_col_d = '0;
                            if (r_row == IW'(N - 1)) begin
                                w_row_d   = '0;
                                w_state_d = StIdle;
                            end else begin
                                w_row_d = r_row + 1'b1;
                            end
                        end else begin
                            w_col_d = r_col + 1'b1;
                        end
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_ld_cnt <= '0;
            r_row    <= '0;
            r_col    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_ld_cnt <= w_ld_cnt_d;
            r_row    <= w_row_d;
            r_col    <= w_col_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(N); i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else begin
            if (w_wr_a) r_a[w_wr_idx] <= i_in_data;
            if (w_wr_b) r_b[w_wr_idx] <= i_in_data;
        end
    end

    // Low PW bits of the product of extended operands are exact for both signednesses.
`ifdef OPS_SIGNED_EN
    assign w_a_ext = {{DW{r_a[r_row][DW-1]}}, r_a[r_row]};
    assign w_b_ext = {{DW{r_b[r_col][DW-1]}}, r_b[r_col]};
`else
    assign w_a_ext = {{DW{1'b0}}, r_a[r_row]};
    assign w_b_ext = {{DW{1'b0}}, r_b[r_col]};
`endif
    assign w_prod = w_a_ext * w_b_ext;

    assign o_in_ready  = (r_state != StStream);
    assign o_out_valid = (r_state == StStream);
    assign o_out_data  = (r_state == StStream) ? w_prod : '0;
    assign o_out_last  = (r_state == StStream) && (r_row == IW'(N - 1)) && (r_col == IW'(N - 1));
    assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_outer_product_stream.sv
// Directed bench for outer_product_stream (N=16, DW=4); follows OPS_SIGNED_EN if defined.
module tb_outer_product_stream;

    localparam int N  = 16;
    localparam int DW = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [3:0]   in_data;
    logic         in_ready;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] ea [N];
    logic [3:0] eb [N];
    logic [7:0] got [N*N];

    typedef struct {
        logic [3:0] a_base;
        logic [3:0] a_step;
        logic [3:0] b_base;
        logic [3:0] b_step;
        bit         gaps;
        int         bp;       // 0 always ready, 1 stall at stall_k, 2 random
        int         stall_k;
        int         probe_k;
        logic [7:0] probe_exp;
    } job_t;

    job_t jobs [6];

    outer_product_stream #(.N(N), .DW(DW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .i_abort     (abort),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_mul(input logic [3:0] a, input logic [3:0] b);
        int sa;
        int sb;
        int p;
`ifdef OPS_SIGNED_EN
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
`else
        sa = int'(a);
        sb = int'(b);
`endif
        p = sa * sb;
        return p[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vectors(input logic [3:0] ab, input logic [3:0] as,
                               input logic [3:0] bb, input logic [3:0] bs);
        for (int i = 0; i < N; i++) begin
            ea[i] = 4'(ab + 4'(i) * as);
            eb[i] = 4'(bb + 4'(i) * bs);
        end
    endtask

    // Presents the first n_elems elements of A then B from ea/eb.
    task automatic load(input bit gaps, input int n_elems);
        for (int e = 0; e < n_elems; e++) begin
            if (gaps && e > 0) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = (e < N) ? ea[e] : eb[e-N];
            check("in_ready_load", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        if (n_elems == 2*N) begin
            check("first_valid_latency", 32'(out_valid), 32'd1);
            check("first_last_low", 32'(out_last), 32'd0);
        end
    endtask

    task automatic collect(input int bp, input int stall_k, input int abort_k, input bit noise);
        int cnt = 0;
        int cyc = 0;
        int stalls = 0;
        logic rdy;
        logic [7:0] exp;
        while (cnt < N*N && cyc < 3000) begin
            exp = model_mul(ea[cnt/N], eb[cnt%N]);
            if (abort_k >= 0 && cnt == abort_k) begin
                abort     = 1'b1;
                out_ready = 1'b0;
                step();
                abort = 1'b0;
                check("abort_valid", 32'(out_valid), 32'd0);
                check("abort_last", 32'(out_last), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                return;
            end
            case (bp)
                1: rdy = !(cnt == stall_k && stalls < 5);
                2: rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b1;
            endcase
            out_ready = rdy;
            in_valid  = noise;
            in_data   = 4'($urandom);
            check("valid_in_stream", 32'(out_valid), 32'd1);
            check("in_ready_stream", 32'(in_ready), 32'd0);
            if (bp == 1 && !rdy) begin
                stalls++;
                check("stall_data", 32'(out_data), 32'(exp));
            end
            if (out_valid && rdy) begin
                check("product", 32'(out_data), 32'(exp));
                check("last_flag", 32'(out_last), 32'(cnt == N*N-1));
                got[cnt] = out_data;
                cnt++;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("output_count", 32'(cnt), 32'(N*N));
        check("end_valid", 32'(out_valid), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;

`ifdef OPS_SIGNED_EN
        jobs[0] = '{4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 0, -1, 0,   8'h01};
        jobs[2] = '{4'h0, 4'h1, 4'h0, 4'h1, 1'b0, 2, -1, 255, 8'h01};
        jobs[5] = '{4'hF, 4'h0, 4'h2, 4'h0, 1'b0, 0, -1, 0,   8'hFE};
`else
        jobs[0] = '{4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 0, -1, 0,   8'hE1};
        jobs[2] = '{4'h0, 4'h1, 4'h0, 4'h1, 1'b0, 2, -1, 255, 8'hE1};
        jobs[5] = '{4'hF, 4'h0, 4'h2, 4'h0, 1'b0, 0, -1, 0,   8'h1E};
`endif
        jobs[1] = '{4'h0, 4'h1, 4'h0, 4'h1, 1'b0, 0, -1, 17,  8'h01};
        jobs[3] = '{4'h0, 4'h1, 4'h0, 4'h1, 1'b0, 1, 37, 37,  8'h0A};
        jobs[4] = '{4'h3, 4'h5, 4'h7, 4'h3, 1'b1, 2, -1, 0,   8'h15};

        #12;
        check_reset_values();
        rst_n = 1'b1;
        step();

        // Jobs run back-to-back from the first IDLE cycle.
        for (int j = 0; j < 6; j++) begin
            set_vectors(jobs[j].a_base, jobs[j].a_step, jobs[j].b_base, jobs[j].b_step);
            load(jobs[j].gaps, 2*N);
            collect(jobs[j].bp, jobs[j].stall_k, -1, jobs[j].gaps);
            check($sformatf("probe_job%0d", j), 32'(got[jobs[j].probe_k]),
                  32'(jobs[j].probe_exp));
        end

        // Abort during LOAD; the element in the abort cycle must be dropped.
        set_vectors(4'h9, 4'h1, 4'h4, 4'h2);
        load(1'b0, 5);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'hF;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_load_busy", 32'(busy), 32'd0);
        set_vectors(4'h1, 4'h3, 4'h2, 4'h5);
        load(1'b0, 2*N);
        collect(0, -1, -1, 1'b0);

        // Abort at output 100, then an all-ones job.
        set_vectors(4'h0, 4'h1, 4'h0, 4'h1);
        load(1'b0, 2*N);
        collect(0, -1, 100, 1'b0);
        step();
        check("abort_hold_idle", 32'(out_valid), 32'd0);
        set_vectors(4'h1, 4'h0, 4'h1, 4'h0);
        load(1'b0, 2*N);
        collect(0, -1, -1, 1'b0);
        check("ones_first", 32'(got[0]), 32'h01);
        check("ones_last", 32'(got[N*N-1]), 32'h01);

        // Reset pulse mid-LOAD.
        set_vectors(4'h5, 4'h1, 4'h6, 4'h1);
        load(1'b0, 10);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        #3;
        rst_n = 1'b1;
        step();
        check_reset_values();
        set_vectors(4'h2, 4'h7, 4'hA, 4'h3);
        load(1'b0, 2*N);
        collect(2, -1, -1, 1'b0);
        check("post_reset_first", 32'(got[0]), 32'(model_mul(4'h2, 4'hA)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
